// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the 256-byte S memory in place using the
// latched key, through a single read/write memory port.
// Optional build macro KSA_INIT_EN: after a start is accepted, first fill
// S[n]=n for n=0..255 (256 extra cycles) before scheduling.
module ksa #(
    parameter int unsigned KEYLEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [8*KEYLEN-1:0] key,
    output logic [7:0]        addr,
    input  logic [7:0]        rddata,
    output logic [7:0]        wrdata,
    output logic              wren
);

    localparam int unsigned KIDX_W = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEYLEN - 1);

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StRdi1,
        StRdi2,
        StCalcj,
        StRdj1,
        StRdj2,
        StWri,
        StWrj,
        StIncr
    } state_e;

    state_e              state_q, state_d;
    logic [8*KEYLEN-1:0] key_q, key_d;
    logic [7:0]          i_q, i_d;
    logic [7:0]          j_q, j_d;
    logic [7:0]          si_q, si_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic                rdy_q, rdy_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          wrdata_q, wrdata_d;
    logic                wren_q, wren_d;
    logic [7:0]          keybyte;

    assign rdy    = rdy_q;
    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;

    // Select key byte kidx, byte 0 being the most significant
    always_comb begin
        keybyte = '0;
        for (int unsigned k = 0; k < KEYLEN; k++) begin
            if (kidx_q == KIDX_W'(k)) keybyte = key_q[8*(KEYLEN-1-k) +: 8];
        end
    end

    // Next state; memory-port outputs are computed for the state being entered
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        kidx_d   = kidx_q;
        rdy_d    = rdy_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    key_d  = key;
                    i_d    = 8'd0;
                    j_d    = 8'd0;
                    kidx_d = '0;
                    rdy_d  = 1'b0;
                    addr_d = 8'd0;
`ifdef KSA_INIT_EN
                    state_d  = StInit;
                    wrdata_d = 8'd0;
                    wren_d   = 1'b1;
`else
                    state_d  = StRdi1;
`endif
                end
            end
`ifdef KSA_INIT_EN
            StInit: begin
                // i doubles as the fill counter; it is back at 0 on exit
                if (i_q == 8'hFF) begin
                    i_d     = 8'd0;
                    addr_d  = 8'd0;
                    state_d = StRdi1;
                end else begin
                    i_d      = i_q + 8'd1;
                    addr_d   = i_q + 8'd1;
                    wrdata_d = i_q + 8'd1;
                    wren_d   = 1'b1;
                end
            end
`endif
            StRdi1: state_d = StRdi2;
            StRdi2: begin
                si_d    = rddata;
                state_d = StCalcj;
            end
            StCalcj: begin
                j_d     = j_q + si_q + keybyte;
                addr_d  = j_q + si_q + keybyte;
                state_d = StRdj1;
            end
            StRdj1: state_d = StRdj2;
            StRdj2: begin
                // rddata is S[j]; it goes straight out as the write to S[i]
                addr_d   = i_q;
                wrdata_d = rddata;
                wren_d   = 1'b1;
                state_d  = StWri;
            end
            StWri: begin
                addr_d   = j_q;
                wrdata_d = si_q;
                wren_d   = 1'b1;
                state_d  = StWrj;
            end
            StWrj: state_d = StIncr;
            StIncr: begin
                if (i_q == 8'hFF) begin
                    rdy_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                    addr_d  = i_q + 8'd1;
                    state_d = StRdi1;
                end
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            key_q    <= '0;
            i_q      <= 8'd0;
            j_q      <= 8'd0;
            si_q     <= 8'd0;
            kidx_q   <= '0;
            rdy_q    <= 1'b1;
            addr_q   <= 8'd0;
            wrdata_q <= 8'd0;
            wren_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            i_q      <= i_d;
            j_q      <= j_d;
            si_q     <= si_d;
            kidx_q   <= kidx_d;
            rdy_q    <= rdy_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
        end
    end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: a software RC4 KSA model predicts every write,
// the final S contents and the run latency. Follows KSA_INIT_EN if defined.
module tb_ksa;

`ifdef KSA_INIT_EN
    localparam int LAT  = 2304;
    localparam int BASE = 256;
`else
    localparam int LAT  = 2048;
    localparam int BASE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;
    logic        load;

    logic [7:0]  mem [256];
    logic [7:0]  exp_s [256];
    logic [15:0] exp_q [$];
    logic [15:0] obs_log [$];

    int checks = 0;
    int errors = 0;

    ksa #(.KEYLEN(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    always #5 clk = ~clk;

    // Synchronous S memory: read data valid one cycle after the address
    always @(posedge clk) begin
        if (load) begin
            for (int n = 0; n < 256; n++) begin
`ifdef KSA_INIT_EN
                mem[n] <= 8'hFF;
`else
                mem[n] <= 8'(n);
`endif
            end
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every write is popped against the model's prediction
    always @(negedge clk) begin
        if (rst_n && wren) begin
            obs_log.push_back({addr, wrdata});
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: got %0h expected none", {addr, wrdata});
            end
            if (exp_q.size() != 0) check("write", {16'd0, addr, wrdata}, {16'd0, exp_q.pop_front()});
            check("wren_while_rdy", {31'd0, rdy}, 32'd0);
        end
    end

    // Software RC4 KSA from the identity permutation
    task automatic build_expect(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] j;
        logic [7:0] t;
        exp_q.delete();
        obs_log.delete();
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
`ifdef KSA_INIT_EN
        for (int n = 0; n < 256; n++) exp_q.push_back({8'(n), 8'(n)});
`endif
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j = j + s[i] + k[8*(2 - (i % 3)) +: 8];
            exp_q.push_back({8'(i), s[j]});
            exp_q.push_back({j, s[i]});
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        for (int n = 0; n < 256; n++) exp_s[n] = s[n];
    endtask

    task automatic do_load();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic start_run(input logic [23:0] k);
        build_expect(k);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        key = ~k;  // must not affect the run
        check("rdy_busy", {31'd0, rdy}, 32'd0);
    endtask

    task automatic wait_done(input bit poke);
        int  cycles = 0;
        bit  done   = 1'b0;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            cycles++;
            #1;
            en = poke && (cycles == 10 || cycles == 1000);
            if (rdy) done = 1'b1;
        end
        en = 1'b0;
        check("latency", cycles, LAT);
    endtask

    task automatic check_final();
        int bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) bad++;
        check("final_s_mismatches", bad, 0);
        check("writes_left", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        key   = '0;
        load  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        check("reset_wren", {31'd0, wren}, 32'd0);
        check("reset_addr", {24'd0, addr}, 32'd0);
        check("reset_wrdata", {24'd0, wrdata}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("idle_state", {29'd0, rdy, wren, |addr}, {29'd0, 3'b100});
        end

        // All-zero key: i=0 self-swap, i=2 swaps S[2] and S[3]
        do_load();
        start_run(24'h000000);
        wait_done(1'b0);
        check_final();
        check("k0_i0_wri", {16'd0, obs_log[BASE+0]}, {16'd0, 16'h0000});
        check("k0_i0_wrj", {16'd0, obs_log[BASE+1]}, {16'd0, 16'h0000});
        check("k0_i2_wri", {16'd0, obs_log[BASE+4]}, {16'd0, 16'h0203});
        check("k0_i2_wrj", {16'd0, obs_log[BASE+5]}, {16'd0, 16'h0302});

        // Key 010203: first swap is S[0] with S[1]
        do_load();
        start_run(24'h010203);
        wait_done(1'b0);
        check_final();
        check("k1_i0_wri", {16'd0, obs_log[BASE+0]}, {16'd0, 16'h0001});
        check("k1_i0_wrj", {16'd0, obs_log[BASE+1]}, {16'd0, 16'h0100});

        // Key 00033C with en pulses while busy that must be ignored
        do_load();
        start_run(24'h00033C);
        wait_done(1'b1);
        check_final();

        // Reset mid-run, then a clean rerun
        do_load();
        start_run(24'h00033C);
        repeat (500) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", {31'd0, rdy}, 32'd1);
        check("midrst_wren", {31'd0, wren}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        do_load();
        start_run(24'h00033C);
        wait_done(1'b0);
        check_final();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ksa.md
Name: ksa

Overview:
- RC4 key-scheduling stage. It permutes the 256-byte S memory in place using the secret key.
- Sits directly upstream of prga: the top level runs ksa to completion, then hands the same S memory to prga for keystream generation and decryption.
- Single S-memory port, same rdy/en handshake as the rest of the ARC4 datapath.

Parameters:
- KEYLEN, 3: key length in bytes; key port width is 8*KEYLEN.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  start request; honoured only when rdy=1.
- rdy  output  1  1 = idle and ready to accept en; 0 = busy.
- key  input  8*KEYLEN  secret key; byte 0 = key[8*KEYLEN-1 -: 8] (MSB first), latched on accepted en.
- addr  output  8  S memory address.
- rddata  input  8  S memory read data, valid one cycle after addr is presented.
- wrdata  output  8  S memory write data.
- wren  output  1  S memory write enable; write occurs at the rising edge while wren=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rdy=1, addr=0, wrdata=0, wren=0, i=0, j=0, kidx=0, key register=0.
- Outputs are registered; they change only on clock edges or on reset assertion.
- Handshake:
  - en sampled at the rising edge; accepted only when in IDLE with rdy=1.
  - On acceptance: latch key, clear i, j, kidx; rdy drops to 0 in the next cycle.
  - en while busy is ignored.
  - If en is held high at completion, a new run starts in the cycle after rdy returns to 1, with the key re-latched.
- Per-iteration sequence (8 cycles per i):
  - RDI1: addr=i, wren=0.
  - RDI2: si <= rddata.
  - CALCJ: j <= j + si + keybyte[kidx], mod 256 (8-bit wrap, carries discarded).
  - RDJ1: addr=j.
  - RDJ2: sj <= rddata.
  - WRI: addr=i, wrdata=sj, wren=1.
  - WRJ: addr=j, wrdata=si, wren=1.
  - INCR: wren=0.
    - If i==255: go to IDLE, rdy=1.
    - Else: i <= i+1; kidx <= (kidx==KEYLEN-1) ? 0 : kidx+1; go to RDI1.
- kidx implements i mod KEYLEN with a wrapping counter; no divider.
- i==j (self-swap): both writes go to the same address with the same value. This is legal and leaves S unchanged.
- wren is high only in WRI/WRJ (and INIT, when enabled), and never in IDLE.
- Run latency, accepted en to rdy=1: exactly 2048 cycles (256x8) without the optional feature.
- Reset mid-run: immediate return to IDLE, rdy=1, wren=0. S contents are left partially permuted; the caller must re-initialise S.
- The key input may change during a run without effect; only the latched copy is used.

Optional Feature:
- Macro KSA_INIT_EN.
- Defined:
  - After acceptance, an INIT state writes S[n]=n for n=0..255, one write per cycle (addr=n, wrdata=n, wren=1), taking 256 cycles.
  - It then enters RDI1 with i=j=kidx=0.
  - Total latency is 2304 cycles, and no separate init block is needed.
- Not defined:
  - No INIT state; S must already hold the identity permutation when en is accepted.
  - Latency is 2048 cycles.

Test Plan:
- Reset then idle: rst_n=0 for one edge, release, en=0 for 2 cycles -> rdy=1, wren=0, addr=0, wrdata=0 throughout.
- key=24'h000000, S=identity:
  - i=0: writes (addr0,data0) twice.
  - i=2: j=3; WRI writes addr2=3, WRJ writes addr3=2.
  - rdy returns high exactly 2048 cycles after en.
- key=24'h010203:
  - i=0: j=1; WRI writes addr0=1, WRJ writes addr1=0.
  - kidx sequence 0,1,2,0 over the first four iterations.
- key=24'h00033C:
  - Final S matches a software RC4 KSA model byte-for-byte.
  - Feeding the result to prga decrypts test1.memh correctly.
- en pulsed while busy at cycles 10 and 1000 -> ignored; completion time unchanged.
- rst_n asserted at cycle 500 -> rdy=1 and wren=0 immediately; a fresh en with S re-initialised yields the correct result.
- KSA_INIT_EN defined, S preloaded with 8'hFF, key=24'h00033C -> cycles 1-256 write S[n]=n, then the final S matches the model; rdy returns after 2304 cycles.
